// File: rtl/clk_rst_ctrl.sv
// PLL bring-up and staged domain reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the mem, core and periph resets in order. Retries on lock timeout, latching FAIL.
module clk_rst_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 64,
  parameter int STAGE_DELAY    = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_soft_rst,
  output logic       o_pll_rst,
  output logic       o_rst_mem,
  output logic       o_rst_core,
  output logic       o_rst_periph,
  output logic       o_ready,
  output logic       o_fail,
  output logic [1:0] o_retries,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    REL_MEM    = 3'd3,
    REL_CORE   = 3'd4,
    REL_PERIPH = 3'd5,
    RUN        = 3'd6,
    FAIL       = 3'd7
  } state_e;

  localparam logic [23:0] PLL_END    = 24'(PLL_RST_CYCLES - 1);
  localparam logic [23:0] TMO_END    = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_END = 24'(LOCK_STABLE - 1);
  localparam logic [23:0] STAGE_END  = 24'(STAGE_DELAY - 1);
  localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  retries_q, retries_d;
  logic        sync1_q, locked_s;
  logic        pll_rst_q, rst_mem_q, rst_core_q, rst_periph_q, ready_q, fail_q;

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    case (state_q)
      PLL_RST:   if (cnt_q == PLL_END) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
        else if (cnt_q == TMO_END) begin
          if (retries_q == RETRY_MAX) state_d = FAIL;
          else begin
            state_d   = PLL_RST;
            retries_d = retries_q + 2'd1;
          end
        end
      end
      // Lock loss is checked ahead of every count-based exit from here on.
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_END) state_d = REL_MEM;
      end
      REL_MEM: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STAGE_END) state_d = REL_CORE;
      end
      REL_CORE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STAGE_END) state_d = REL_PERIPH;
      end
      REL_PERIPH: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STAGE_END) begin
          state_d   = RUN;
          retries_d = 2'd0;
        end
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (i_soft_rst) state_d = REL_MEM;
      end
      FAIL:    state_d = FAIL;
      default: state_d = PLL_RST;
    endcase
    cnt_d = (state_d != state_q) ? 24'd0 : cnt_q + 24'd1;
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= 24'd0;
      retries_q    <= 2'd0;
      sync1_q      <= 1'b0;
      locked_s     <= 1'b0;
      pll_rst_q    <= 1'b1;
      rst_mem_q    <= 1'b1;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      sync1_q      <= i_locked;
      locked_s     <= sync1_q;
      pll_rst_q    <= (state_d == PLL_RST) || (state_d == FAIL);
      rst_mem_q    <= (state_d == PLL_RST) || (state_d == WAIT_LOCK) ||
                      (state_d == STABLE)  || (state_d == FAIL);
      rst_core_q   <= (state_d == PLL_RST) || (state_d == WAIT_LOCK) ||
                      (state_d == STABLE)  || (state_d == REL_MEM) || (state_d == FAIL);
      rst_periph_q <= (state_d == PLL_RST) || (state_d == WAIT_LOCK) ||
                      (state_d == STABLE)  || (state_d == REL_MEM) ||
                      (state_d == REL_CORE) || (state_d == FAIL);
      ready_q      <= (state_d == RUN);
      fail_q       <= fail_q || (state_d == FAIL);
    end
  end

  assign o_pll_rst    = pll_rst_q;
  assign o_rst_mem    = rst_mem_q;
  assign o_rst_core   = rst_core_q;
  assign o_rst_periph = rst_periph_q;
  assign o_ready      = ready_q;
  assign o_fail       = fail_q;
  assign o_retries    = retries_q;
  assign o_state      = state_q;

endmodule
